// File: rtl/carfield_apb_periph_demux.sv
// Registered APB demultiplexer for the Carfield peripheral window (CAN, timers, watchdog, HyperBus cfg).
// Optional ACCESS-phase timeout is built in when CARFIELD_APB_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for an upstream setup phase; downstream fields hold last value
// SETUP  | downstream setup phase on the decoded slot
// ACCESS | downstream access phase, waiting for the slot's pready
// RESP   | forwarding the slot's response upstream for one cycle
// ERR    | issuing the local error response for one cycle
module carfield_apb_periph_demux #(
   parameter int unsigned NumSlv = 5,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter logic [NumSlv-1:0][AddrWidth-1:0] SlvBase = {32'h2000_9000, 32'h2000_7000,
                                                          32'h2000_5000, 32'h2000_4000,
                                                          32'h2000_1000},
   parameter logic [NumSlv-1:0][AddrWidth-1:0] SlvMask = {NumSlv{32'hFFFF_F000}},
   parameter logic [NumSlv-1:0] SlvEnable = {NumSlv{1'b1}},
   parameter int unsigned TimeoutCycles = 255,
   parameter logic [DataWidth-1:0] ErrData = 32'hBADC_AB1E
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [AddrWidth-1:0]                paddr_i,
   input  logic                                pwrite_i,
   input  logic                                psel_i,
   input  logic                                penable_i,
   input  logic [DataWidth-1:0]                pwdata_i,
   input  logic [DataWidth/8-1:0]              pstrb_i,
   output logic [DataWidth-1:0]                prdata_o,
   output logic                                pready_o,
   output logic                                pslverr_o,
   output logic [AddrWidth-1:0]                paddr_o,
   output logic                                pwrite_o,
   output logic [DataWidth-1:0]                pwdata_o,
   output logic [DataWidth/8-1:0]              pstrb_o,
   output logic [NumSlv-1:0]                   psel_o,
   output logic                                penable_o,
   input  logic [NumSlv-1:0][DataWidth-1:0]    prdata_i,
   input  logic [NumSlv-1:0]                   pready_i,
   input  logic [NumSlv-1:0]                   pslverr_i,
   output logic [15:0]                         err_cnt_o,
   output logic [AddrWidth-1:0]                err_addr_o
);

   localparam int unsigned SlotW = (NumSlv > 1) ? $clog2(NumSlv) : 1;

   if (TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_timeout
      $error("TimeoutCycles must be within 1..65535");
   end

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_e;

   state_e              state;
   logic [SlotW-1:0]    slot;
   logic                dec_hit;
   logic [SlotW-1:0]    dec_slot;
   logic [NumSlv-1:0]   dec_onehot;
   logic [15:0]         err_cnt_inc;

`ifdef CARFIELD_APB_TIMEOUT_EN
   logic [15:0]         tmo_cnt;
`endif

   // Scan from the top down so the lowest matching slot is the one left standing.
   always_comb begin
      dec_hit    = 1'b0;
      dec_slot   = '0;
      dec_onehot = '0;
      for (int i = NumSlv - 1; i >= 0; i--) begin
         if (SlvEnable[i] && ((paddr_i & SlvMask[i]) == SlvBase[i])) begin
            dec_hit  = 1'b1;
            dec_slot = SlotW'(i);
         end
      end
      if (dec_hit) begin
         dec_onehot[dec_slot] = 1'b1;
      end
   end

   assign err_cnt_inc = (err_cnt_o == 16'hFFFF) ? err_cnt_o : err_cnt_o + 16'd1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         slot       <= '0;
         psel_o     <= '0;
         penable_o  <= 1'b0;
         pready_o   <= 1'b0;
         pslverr_o  <= 1'b0;
         prdata_o   <= '0;
         paddr_o    <= '0;
         pwrite_o   <= 1'b0;
         pwdata_o   <= '0;
         pstrb_o    <= '0;
         err_cnt_o  <= '0;
         err_addr_o <= '0;
`ifdef CARFIELD_APB_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         pready_o  <= 1'b0;
         pslverr_o <= 1'b0;
         prdata_o  <= '0;
         case (state)
            IDLE: begin
               if (psel_i && !penable_i) begin
                  paddr_o  <= paddr_i;
                  pwrite_o <= pwrite_i;
                  pwdata_o <= pwdata_i;
                  pstrb_o  <= pstrb_i;
                  slot     <= dec_slot;
                  if (dec_hit) begin
                     psel_o <= dec_onehot;
                     state  <= SETUP;
                  end else begin
                     pready_o   <= 1'b1;
                     pslverr_o  <= 1'b1;
                     prdata_o   <= ErrData;
                     err_cnt_o  <= err_cnt_inc;
                     err_addr_o <= paddr_i;
                     state      <= ERR;
                  end
               end
            end
            SETUP: begin
               penable_o <= 1'b1;
`ifdef CARFIELD_APB_TIMEOUT_EN
               tmo_cnt   <= '0;
`endif
               state     <= ACCESS;
            end
            ACCESS: begin
               // A late pready still beats the timeout in the same cycle.
               if (pready_i[slot]) begin
                  psel_o    <= '0;
                  penable_o <= 1'b0;
                  pready_o  <= 1'b1;
                  pslverr_o <= pslverr_i[slot];
                  prdata_o  <= prdata_i[slot];
                  state     <= RESP;
               end
`ifdef CARFIELD_APB_TIMEOUT_EN
               else if (tmo_cnt == 16'(TimeoutCycles)) begin
                  psel_o     <= '0;
                  penable_o  <= 1'b0;
                  pready_o   <= 1'b1;
                  pslverr_o  <= 1'b1;
                  prdata_o   <= ErrData;
                  err_cnt_o  <= err_cnt_inc;
                  err_addr_o <= paddr_o;
                  state      <= ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            RESP:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_carfield_apb_periph_demux.sv
// Scoreboard bench for carfield_apb_periph_demux: driver pushes expected responses, monitor pops on pready_o.
// Slot 0 is disabled and TimeoutCycles is 4 so the disable and timeout paths are reachable.
module tb_carfield_apb_periph_demux;
   localparam int NS = 5;
   localparam int AW = 32;
   localparam int DW = 32;

   logic                 clk_sys = 1'b0;
   logic                 rst_i = 1'b1;
   logic [AW-1:0]        paddr_i = '0;
   logic                 pwrite_i = 1'b0;
   logic                 psel_i = 1'b0;
   logic                 penable_i = 1'b0;
   logic [DW-1:0]        pwdata_i = '0;
   logic [DW/8-1:0]      pstrb_i = '0;
   logic [DW-1:0]        prdata_o;
   logic                 pready_o;
   logic                 pslverr_o;
   logic [AW-1:0]        paddr_o;
   logic                 pwrite_o;
   logic [DW-1:0]        pwdata_o;
   logic [DW/8-1:0]      pstrb_o;
   logic [NS-1:0]        psel_o;
   logic                 penable_o;
   logic [NS-1:0][DW-1:0] prdata_i = '0;
   logic [NS-1:0]        pready_i = '0;
   logic [NS-1:0]        pslverr_i = '0;
   logic [15:0]          err_cnt_o;
   logic [AW-1:0]        err_addr_o;

   always #5 clk_sys = ~clk_sys;

   carfield_apb_periph_demux #(
      .SlvEnable(5'b11110),
      .TimeoutCycles(4)
   ) dut (
      .clk_i(clk_sys), .rst_i(rst_i),
      .paddr_i(paddr_i), .pwrite_i(pwrite_i), .psel_i(psel_i), .penable_i(penable_i),
      .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
      .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
      .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
      .psel_o(psel_o), .penable_o(penable_o),
      .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
      .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      int          lat;
      int          start;
      logic [4:0]  psel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        wr;
      logic [15:0] ecnt;
      logic [31:0] eaddr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;

   int          cfg_waits = 0;
   logic [31:0] cfg_rdata = '0;
   logic        cfg_err = 1'b0;
   int          wcnt = 0;
   logic [4:0]  seen_psel = '0;
   logic [31:0] seen_addr = '0;
   logic [31:0] seen_wdata = '0;
   logic [3:0]  seen_strb = '0;
   logic        seen_wr = 1'b0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Downstream subordinate model: cfg_waits wait states, then pready on the selected slot.
   initial begin
      forever begin
         @(negedge clk_sys);
         pready_i  = '0;
         pslverr_i = '0;
         for (int s = 0; s < NS; s++) prdata_i[s] = cfg_rdata;
         if (psel_o != '0) begin
            seen_psel  = seen_psel | psel_o;
            seen_addr  = paddr_o;
            seen_wdata = pwdata_o;
            seen_strb  = pstrb_o;
            seen_wr    = pwrite_o;
         end
         if (penable_o && psel_o != '0) begin
            if (wcnt == cfg_waits) begin
               pready_i  = psel_o;
               pslverr_i = cfg_err ? psel_o : '0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk_sys);
         chk("psel_onehot_slot0_off", {31'd0, $onehot0(psel_o) && !psel_o[0]}, 32'd1);
         if (pready_o === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_pready: got pready_o=1 expected no response pending");
            end else begin
               e = sb.pop_front();
               chk("prdata", prdata_o, e.rdata);
               chk("pslverr", {31'd0, pslverr_o}, {31'd0, e.slverr});
               chk("latency", cyc - e.start, e.lat);
               chk("psel_in_resp", {27'd0, psel_o}, 32'd0);
               chk("psel_seen", {27'd0, seen_psel}, {27'd0, e.psel});
               if (e.psel != '0) begin
                  chk("paddr_fwd", seen_addr, e.addr);
                  chk("pwdata_fwd", seen_wdata, e.wdata);
                  chk("pstrb_fwd", {28'd0, seen_strb}, {28'd0, e.strb});
                  chk("pwrite_fwd", {31'd0, seen_wr}, {31'd0, e.wr});
               end
               chk("err_cnt", {16'd0, err_cnt_o}, {16'd0, e.ecnt});
               chk("err_addr", err_addr_o, e.eaddr);
            end
         end
      end
   end

   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int waits, input logic [31:0] srdata,
                       input logic serr, input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input logic [4:0] exp_psel, input logic [15:0] ecnt,
                       input logic [31:0] eaddr);
      exp_t e;
      int   n;
      @(negedge clk_sys);
      cfg_waits = waits;
      cfg_rdata = srdata;
      cfg_err   = serr;
      seen_psel = '0;
      paddr_i   = addr;
      pwrite_i  = wr;
      pwdata_i  = wdata;
      pstrb_i   = strb;
      psel_i    = 1'b1;
      penable_i = 1'b0;
      e.rdata = exp_rdata; e.slverr = exp_err; e.lat = lat; e.start = cyc;
      e.psel = exp_psel; e.addr = addr; e.wdata = wdata; e.strb = strb; e.wr = wr;
      e.ecnt = ecnt; e.eaddr = eaddr;
      sb.push_back(e);
      @(negedge clk_sys);
      penable_i = 1'b1;
      n = 0;
      while (pready_o !== 1'b1 && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= 100) begin
         checks++;
         fails++;
         $display("FAIL xfer_bound: got no pready_o within 100 cycles for addr %h expected a response", addr);
      end
      @(negedge clk_sys);
      psel_i    = 1'b0;
      penable_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_psel"}, {27'd0, psel_o}, 32'd0);
      chk({tag, "_penable"}, {31'd0, penable_o}, 32'd0);
      chk({tag, "_pready"}, {31'd0, pready_o}, 32'd0);
      chk({tag, "_pslverr"}, {31'd0, pslverr_o}, 32'd0);
      chk({tag, "_prdata"}, prdata_o, 32'd0);
      chk({tag, "_paddr"}, paddr_o, 32'd0);
      chk({tag, "_pwdata"}, pwdata_o, 32'd0);
      chk({tag, "_pstrb"}, {28'd0, pstrb_o}, 32'd0);
      chk({tag, "_pwrite"}, {31'd0, pwrite_o}, 32'd0);
      chk({tag, "_err_cnt"}, {16'd0, err_cnt_o}, 32'd0);
      chk({tag, "_err_addr"}, err_addr_o, 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk_sys);
      check_reset_outputs("reset");
      rst_i = 1'b0;

      // addr, wr, wdata, strb, waits, slave rdata, slave err, exp rdata, exp err, latency, psel, err_cnt, err_addr
      xfer(32'h2000_4010, 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0,
           32'h1234_5678, 1'b0, 3, 5'b00010, 16'd0, 32'h0);
      xfer(32'h2000_9004, 1'b1, 32'hA5A5_A5A5, 4'hF, 3, 32'h0, 1'b0,
           32'h0, 1'b0, 6, 5'b10000, 16'd0, 32'h0);
      xfer(32'h2000_2000, 1'b0, 32'h0, 4'h0, 0, 32'h1111_1111, 1'b0,
           32'hBADC_AB1E, 1'b1, 1, 5'b00000, 16'd1, 32'h2000_2000);
      xfer(32'h2000_1000, 1'b0, 32'h0, 4'h0, 0, 32'h2222_2222, 1'b0,
           32'hBADC_AB1E, 1'b1, 1, 5'b00000, 16'd2, 32'h2000_1000);
      xfer(32'h2000_5FFC, 1'b0, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 1'b1,
           32'hDEAD_BEEF, 1'b1, 4, 5'b00100, 16'd2, 32'h2000_1000);
`ifdef CARFIELD_APB_TIMEOUT_EN
      xfer(32'h2000_7008, 1'b0, 32'h0, 4'h0, 1000, 32'h3333_3333, 1'b0,
           32'hBADC_AB1E, 1'b1, 7, 5'b01000, 16'd3, 32'h2000_7008);
      xfer(32'h2000_700C, 1'b0, 32'h0, 4'h0, 4, 32'h0F0F_0F0F, 1'b0,
           32'h0F0F_0F0F, 1'b0, 7, 5'b01000, 16'd3, 32'h2000_7008);
`else
      xfer(32'h2000_700C, 1'b0, 32'h0, 4'h0, 10, 32'h0F0F_0F0F, 1'b0,
           32'h0F0F_0F0F, 1'b0, 13, 5'b01000, 16'd2, 32'h2000_1000);
`endif

      // Reset while the downstream access is pending on a stalled slot 3.
      @(negedge clk_sys);
      cfg_waits = 1000;
      paddr_i   = 32'h2000_7000;
      pwrite_i  = 1'b1;
      pwdata_i  = 32'h5555_AAAA;
      pstrb_i   = 4'h3;
      psel_i    = 1'b1;
      penable_i = 1'b0;
      @(negedge clk_sys);
      penable_i = 1'b1;
      n = 0;
      while (penable_o !== 1'b1 && n < 20) begin
         @(negedge clk_sys);
         n++;
      end
      chk("reached_access", {31'd0, penable_o}, 32'd1);
      rst_i     = 1'b1;
      psel_i    = 1'b0;
      penable_i = 1'b0;
      @(negedge clk_sys);
      check_reset_outputs("mid_access_reset");
      rst_i = 1'b0;

      xfer(32'h2000_4000, 1'b0, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0,
           32'hCAFE_F00D, 1'b0, 3, 5'b00010, 16'd0, 32'h0);
      xfer(32'h2000_0FFC, 1'b1, 32'h1, 4'h1, 0, 32'h0, 1'b0,
           32'hBADC_AB1E, 1'b1, 1, 5'b00000, 16'd1, 32'h2000_0FFC);

      repeat (3) @(negedge clk_sys);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got simulation still running expected completion");
      $fatal(1, "time limit");
   end
endmodule
